uart_tx: RTL

UART transmitter: serializes one 8-bit word per request into an 8N1 frame on `tx`, paced by the shared 16x oversampling tick. Sits directly downstream of the debug/loopback controller: it consumes `tx_dato_in`/`tx_start` and returns `tx_done`. It mirrors the receiver on the same tick, so both directions share one baud generator.

---
 rtl/uart_tx.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter paced by the shared 16x oversampling tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] tx_dato_in,
  output logic            tx,
  output logic            tx_done
);

  // state  | meaning
  // IDLE   | line high, waiting for tx_start with tx_done low
  // START  | start bit (low), 16 ticks
  // DATA   | data bits LSB first, 16 ticks each
  // PARITY | even parity of the captured word, 16 ticks (parity builds only)
  // STOP   | stop bit (high), SB_TICK ticks, then tx_done pulse
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

  // Tick counter must also hold SB_TICK-1 for 1.5/2 stop-bit settings.
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  logic [2:0]      state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            tx_next;
`ifdef UART_TX_PARITY_EN
  logic            par;
`endif

  // tx is registered from the current state, so it trails the state by one clock.
  always_comb begin
    tx_next = 1'b1;
    case (state)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = b[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = par;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      s       <= '0;
      n       <= '0;
      b       <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      tx      <= tx_next;
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Ignoring requests during tx_done lets a holding upstream release cleanly.
          if (tx_start && !tx_done) begin
            b     <= tx_dato_in;
            s     <= '0;
            state <= ST_START;
`ifdef UART_TX_PARITY_EN
            par   <= ^tx_dato_in;
`endif
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (s == S_BIT_LAST) begin
              s     <= '0;
              n     <= '0;
              state <= ST_DATA;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (s == S_BIT_LAST) begin
              s <= '0;
              b <= b >> 1;
              if (n == N_LAST) state <= ST_AFTER_DATA;
              else             n     <= n + 1'b1;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (s_tick) begin
            if (s == S_BIT_LAST) begin
              s     <= '0;
              state <= ST_STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif
        ST_STOP: begin
          if (s_tick) begin
            if (s == S_STOP_LAST) begin
              s       <= '0;
              state   <= ST_IDLE;
              tx_done <= 1'b1;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          s     <= '0;
        end
      endcase
    end
  end

endmodule
